dcache_wb_buffer: RTL and testbench
===================================

Name: dcache_wb_buffer

Overview:
- Consumer side of the dcache eviction path: accepts dirty-line evictions pulsed by the dcache memory array (evict_en/evict_addr/evict_data) and queues them in a small FIFO.
- Drains entries to main memory as BUS_STORE requests through the shared memory bus.
- Provides a combinational lookup port so a dcache fill cannot fetch stale data for a line still waiting to be written back.

Parameters:
- DEPTH, 4, number of buffered 64-bit lines (power of two, ≥2).
- ADDR_W, 32, address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = asserted)
- evict_en  in  1  one-cycle eviction push from dcache
- evict_addr  in  ADDR_W  evicted line address, bits [2:0] = 0
- evict_data  in  64  evicted line data
- evict_ready  out  1  buffer can accept a push this cycle
- overflow_err  out  1  sticky: a push was dropped
- lookup_addr  in  ADDR_W  fill address to check
- lookup_hit  out  1  a matching line is pending
- lookup_data  out  64  data of the youngest matching line
- bus_grant  in  1  memory arbiter grants the bus to this block
- mem2proc_response  in  4  nonzero = request accepted
- wb_command  out  2  BUS_NONE / BUS_STORE
- wb_addr  out  ADDR_W  store address
- wb_data  out  64  store data
- count  out  $clog2(DEPTH)+1  occupancy
- empty  out  1  count == 0

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, head=tail=0, all valid bits=0, state=IDLE, overflow_err=0.
  - wb_command=BUS_NONE, wb_addr=0, wb_data=0, lookup_hit=0, lookup_data=0.
- Storage: circular FIFO of {addr, data, valid}. Pointers wrap modulo DEPTH.
- Push:
  - On a clock edge with evict_en=1 and accept, write the entry at tail, advance tail, count+1.
  - Accept = (count<DEPTH) OR (pop in the same cycle).
  - evict_ready = (count<DEPTH).
- Full push: evict_en=1, count==DEPTH and no pop that cycle → push dropped, overflow_err set to 1 until reset.
- FSM:
  - IDLE: wb_command=BUS_NONE. Move to ISSUE when count>0 (takes one cycle).
  - ISSUE: wb_command=BUS_STORE, wb_addr/wb_data = head entry (combinational from registered state and head).
  - Pop condition: bus_grant=1 AND mem2proc_response!=0 → head valid cleared, head advances, count-1. Next state is ISSUE if the remaining count>0, otherwise IDLE.
  - Grant without a nonzero response, or no grant: hold the request unchanged, no pop.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at full and at count=1.
- Lookup (combinational):
  - Compare lookup_addr[ADDR_W-1:3] against all valid entries and against the same-cycle incoming push (evict_en=1 and accepted).
  - Priority: incoming push > youngest entry > older entries.
  - No match: lookup_hit=0, lookup_data=0.
  - The head entry matches even while it is being issued. It drops out of lookup only after it pops.
- Latency: a push into an empty buffer in cycle N → ISSUE in N+1 → BUS_STORE asserted during N+1. At most one store retires per cycle.
- Mid-operation reset: the FSM returns to IDLE immediately and all pending lines are discarded. wb_command goes to BUS_NONE asynchronously.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a push whose address matches a valid non-head entry overwrites that entry's data in place. Tail and count are unchanged. This is allowed even when full, with no overflow. The head entry is never overwritten while in ISSUE: a push matching the head appends a new entry instead.
- Undefined: every accepted push appends. Duplicate addresses may coexist and drain in FIFO order.

Test Plan:
- Single push addr=0x0000_1040, data=0xDEAD_BEEF_0000_0001, grant=1, response=3 from the cycle after the push → BUS_STORE for exactly one cycle with that addr/data, then empty=1 and wb_command=BUS_NONE.
- Push 4 lines with grant=0, then a 5th push → evict_ready=0, overflow_err=1, count=4. Raise grant with response=1 → four stores in push order, one per cycle.
- Full buffer: in one cycle evict_en=1 with grant=1 and response=2 → no overflow, count stays 4, and the new line drains last.
- Pending addr 0x2000 with data A, then push 0x2000 with data B while the head (a different address) is stalled → lookup_addr=0x2004 returns hit=1, data=B. With WB_COALESCE_EN, count increments only once.
- Grant=1 with response=0 for 3 cycles → request held stable and count unchanged. Response=5 on the 4th cycle → pop.
- Assert reset=0 mid-ISSUE with count=3 → count=0, wb_command=BUS_NONE, lookup_hit=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dcache_wb_buffer.sv
// Dcache write-back buffer: queues dirty-line evictions, drains them as BUS_STORE
// requests, and exposes a combinational lookup for pending lines. Optional WB_COALESCE_EN.
module dcache_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       evict_en,
    input  logic [ADDR_W-1:0]          evict_addr,
    input  logic [63:0]                evict_data,
    output logic                       evict_ready,
    output logic                       overflow_err,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [63:0]                lookup_data,
    input  logic                       bus_grant,
    input  logic [3:0]                 mem2proc_response,
    output logic [1:0]                 wb_command,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic [63:0]                wb_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wb_entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    wb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;

    logic          pop, full, accept, push_app, coal_hit, coal_wr, drop;
    logic [PW-1:0] coal_idx, l_idx;
    logic          lookup_unused;

    assign lookup_unused = ^lookup_addr[2:0];

    assign pop         = (state_q == ISSUE) && bus_grant && (mem2proc_response != 4'd0);
    assign full        = (count_q == CW'(DEPTH));
    assign accept      = !full || pop;
    assign evict_ready = !full;
    assign count       = count_q;
    assign empty       = (count_q == '0);

`ifdef WB_COALESCE_EN
    // Offset 0 is the head: it may be on the bus, so it is never a merge target.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (vld_q[head_q + PW'(i)] &&
                ent_q[head_q + PW'(i)].addr[ADDR_W-1:3] == evict_addr[ADDR_W-1:3]) begin
                coal_hit = 1'b1;
                coal_idx = head_q + PW'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign coal_wr  = evict_en && coal_hit;
    assign push_app = evict_en && accept && !coal_hit;
    assign drop     = evict_en && !accept && !coal_hit;
    assign count_d  = count_q + CW'(push_app) - CW'(pop);

    // Walk oldest to youngest so the youngest match wins; the incoming push beats all.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        l_idx       = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            l_idx = head_q + PW'(i);
            if (vld_q[l_idx] && ent_q[l_idx].addr[ADDR_W-1:3] == lookup_addr[ADDR_W-1:3]) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_q[l_idx].data;
            end
        end
        if (reset && evict_en && (accept || coal_hit) &&
            evict_addr[ADDR_W-1:3] == lookup_addr[ADDR_W-1:3]) begin
            lookup_hit  = 1'b1;
            lookup_data = evict_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_command = BUS_NONE;
        wb_addr    = '0;
        wb_data    = '0;
        case (state_q)
            IDLE: begin
                if (count_d != '0) state_d = ISSUE;
            end
            ISSUE: begin
                wb_command = BUS_STORE;
                wb_addr    = ent_q[head_q].addr;
                wb_data    = ent_q[head_q].data;
                if (pop) state_d = (count_d != '0) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            vld_q        <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            // Push after pop: at full the pushed slot is the one being vacated.
            if (push_app) begin
                ent_q[tail_q].addr <= evict_addr;
                ent_q[tail_q].data <= evict_data;
                vld_q[tail_q]      <= 1'b1;
                tail_q             <= tail_q + PW'(1);
            end
            if (coal_wr) ent_q[coal_idx].data <= evict_data;
            if (drop) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer; inputs driven and outputs sampled on the falling edge.
module tb_dcache_wb_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        evict_en;
    logic [31:0] evict_addr;
    logic [63:0] evict_data;
    logic        evict_ready;
    logic        overflow_err;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic [63:0] lookup_data;
    logic        bus_grant;
    logic [3:0]  mem2proc_response;
    logic [1:0]  wb_command;
    logic [31:0] wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    dcache_wb_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .evict_en(evict_en), .evict_addr(evict_addr), .evict_data(evict_data),
        .evict_ready(evict_ready), .overflow_err(overflow_err),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .bus_grant(bus_grant), .mem2proc_response(mem2proc_response),
        .wb_command(wb_command), .wb_addr(wb_addr), .wb_data(wb_data),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d);
        evict_en = 1'b1; evict_addr = a; evict_data = d;
        tick();
        evict_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; evict_en = 1'b0; evict_addr = '0; evict_data = '0;
        lookup_addr = '0; bus_grant = 1'b0; mem2proc_response = '0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_cmd", wb_command, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_hit", lookup_hit, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_ready", evict_ready, 1);
        tick();
        reset = 1'b1;
        tick();

        // single push, one-cycle store
        evict_en = 1'b1; evict_addr = 32'h0000_1040; evict_data = 64'hDEAD_BEEF_0000_0001;
        lookup_addr = 32'h0000_1040;
        #1;
        chk("t1_inflight_hit", lookup_hit, 1);
        chk("t1_inflight_data", lookup_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        evict_en = 1'b0; bus_grant = 1'b1; mem2proc_response = 4'd3;
        #1;
        chk("t1_cmd", wb_command, 2);
        chk("t1_addr", wb_addr, 32'h0000_1040);
        chk("t1_data", wb_data, 64'hDEAD_BEEF_0000_0001);
        chk("t1_count", count, 1);
        tick();
        chk("t1_empty", empty, 1);
        chk("t1_cmd_after", wb_command, 0);
        chk("t1_hit_after", lookup_hit, 0);
        bus_grant = 1'b0; mem2proc_response = 4'd0;

        // fill, overflow, ordered drain
        for (int k = 0; k < 4; k++) push(32'h100 + 32'(8 * k), 64'h1100 + 64'(k));
        chk("t2_count4", count, 4);
        chk("t2_ready", evict_ready, 0);
        chk("t2_ovf_pre", overflow_err, 0);
        push(32'h120, 64'hBAD);
        chk("t2_count_ovf", count, 4);
        chk("t2_ovf", overflow_err, 1);
        bus_grant = 1'b1; mem2proc_response = 4'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t2_cmd%0d", k), wb_command, 2);
            chk($sformatf("t2_addr%0d", k), wb_addr, 32'h100 + 32'(8 * k));
            chk($sformatf("t2_data%0d", k), wb_data, 64'h1100 + 64'(k));
            tick();
        end
        chk("t2_empty", empty, 1);
        chk("t2_cmd_idle", wb_command, 0);
        bus_grant = 1'b0; mem2proc_response = 4'd0;

        // asynchronous reset in the middle of ISSUE
        for (int k = 0; k < 3; k++) push(32'h400 + 32'(8 * k), 64'h4400 + 64'(k));
        lookup_addr = 32'h400;
        #1;
        chk("t6_count3", count, 3);
        chk("t6_cmd", wb_command, 2);
        chk("t6_hit_pre", lookup_hit, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_cmd_rst", wb_command, 0);
        chk("t6_hit", lookup_hit, 0);
        chk("t6_ovf", overflow_err, 0);
        tick();
        reset = 1'b1;
        tick();

        // simultaneous push and pop at full
        for (int k = 0; k < 4; k++) push(32'h200 + 32'(8 * k), 64'h2200 + 64'(k));
        evict_en = 1'b1; evict_addr = 32'h220; evict_data = 64'h2204;
        bus_grant = 1'b1; mem2proc_response = 4'd2;
        tick();
        evict_en = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow_err, 0);
        for (int k = 1; k < 5; k++) begin
            #1;
            chk($sformatf("t3_addr%0d", k), wb_addr, 32'h200 + 32'(8 * k));
            chk($sformatf("t3_data%0d", k), wb_data, 64'h2200 + 64'(k));
            tick();
        end
        chk("t3_empty", empty, 1);
        bus_grant = 1'b0; mem2proc_response = 4'd0;

        // lookup of a duplicated address while the head is stalled
        push(32'h3000, 64'h3333);
        push(32'h2000, 64'hAAAA);
        evict_en = 1'b1; evict_addr = 32'h2000; evict_data = 64'hBBBB;
        lookup_addr = 32'h2004;
        #1;
        chk("t4_inc_hit", lookup_hit, 1);
        chk("t4_inc_data", lookup_data, 64'hBBBB);
        tick();
        evict_en = 1'b0;
        #1;
        chk("t4_hit", lookup_hit, 1);
        chk("t4_data", lookup_data, 64'hBBBB);
`ifdef WB_COALESCE_EN
        chk("t4_count", count, 2);
`else
        chk("t4_count", count, 3);
`endif
        lookup_addr = 32'h3000;
        #1;
        chk("t4_head_hit", lookup_hit, 1);
        chk("t4_head_data", lookup_data, 64'h3333);
        lookup_addr = 32'h5000;
        #1;
        chk("t4_miss_hit", lookup_hit, 0);
        chk("t4_miss_data", lookup_data, 0);

        // grant without response holds the request
        bus_grant = 1'b1; mem2proc_response = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_hold_addr%0d", k), wb_addr, 32'h3000);
            chk($sformatf("t5_hold_data%0d", k), wb_data, 64'h3333);
`ifdef WB_COALESCE_EN
            chk($sformatf("t5_hold_count%0d", k), count, 2);
`else
            chk($sformatf("t5_hold_count%0d", k), count, 3);
`endif
        end
        mem2proc_response = 4'd5;
        tick();
        mem2proc_response = 4'd0;
        lookup_addr = 32'h3000;
        #1;
        chk("t5_pop_addr", wb_addr, 32'h2000);
`ifdef WB_COALESCE_EN
        chk("t5_pop_data", wb_data, 64'hBBBB);
        chk("t5_pop_count", count, 1);
`else
        chk("t5_pop_data", wb_data, 64'hAAAA);
        chk("t5_pop_count", count, 2);
`endif
        chk("t5_head_gone", lookup_hit, 0);
        mem2proc_response = 4'd1;
        for (int k = 0; k < 3; k++) tick();
        chk("t5_empty", empty, 1);
        chk("t5_cmd", wb_command, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
